// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states, iteration count.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int unsigned DIV_ITER = 32;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StFix
    } md_state_e;

endpackage

// File: rtl/md_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface md_unit_if;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] OpA;
    logic [31:0] OpB;
    logic        Abort;
    logic        Busy;
    logic [31:0] Hi;
    logic [31:0] Lo;

    modport master (
        output Start, Op, OpA, OpB, Abort,
        input  Busy, Hi, Lo
    );

    modport slave (
        input  Start, Op, OpA, OpB, Abort,
        output Busy, Hi, Lo
    );
endinterface

// File: rtl/md_divider.sv
// Unsigned 32-bit restoring divider, one quotient bit per step, MSB first.
module md_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic [33:0] shifted;
    logic [33:0] diff;
    logic        unused_bits;

    // Quotient register doubles as the dividend shift register.
    assign shifted = {1'b0, rem_q, quo_q[31]};
    assign diff    = shifted - {2'b00, dvs_q};
    assign unused_bits = ^{shifted[33:32], diff[32]};

    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        if (load) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
        end else if (step) begin
            if (!diff[33]) begin
                rem_d = diff[31:0];
                quo_d = {quo_q[30:0], 1'b1};
            end else begin
                rem_d = shifted[31:0];
                quo_d = {quo_q[30:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/md_unit.sv
// MIPS32 multiply/divide unit with architectural HI/LO. Multiply is a held registered product;
// divide runs the restoring iterator then a sign-fix cycle.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 4
) (
    input logic       clk,
    input logic       rst,
    md_unit_if.slave  bus
);

    localparam logic [4:0] MulCntInit = 5'(MUL_CYCLES - 1);
    localparam logic [4:0] DivCntInit = 5'(DIV_ITER - 1);

    md_state_e   state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [63:0] prod_q, prod_d;
    logic [31:0] opa_q, opa_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        div0_q, div0_d;

    logic        div_load, div_step, div_signed;
    logic [31:0] mag_a, mag_b;
    logic [31:0] div_quo, div_rem;
    logic [63:0] smul, umul;

    assign smul = $signed({{32{bus.OpA[31]}}, bus.OpA}) * $signed({{32{bus.OpB[31]}}, bus.OpB});
    assign umul = {32'd0, bus.OpA} * {32'd0, bus.OpB};

    assign div_signed = (bus.Op == MD_DIV);
    assign mag_a = (div_signed && bus.OpA[31]) ? -bus.OpA : bus.OpA;
    assign mag_b = (div_signed && bus.OpB[31]) ? -bus.OpB : bus.OpB;

    md_divider u_divider (
        .clk       (clk),
        .rst       (rst),
        .load      (div_load),
        .step      (div_step),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        prod_d   = prod_q;
        opa_d    = opa_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        div0_d   = div0_q;
        div_load = 1'b0;
        div_step = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.Start && !bus.Abort) begin
                    case (bus.Op)
                        MD_MULT, MD_MULTU: begin
                            prod_d  = (bus.Op == MD_MULT) ? smul : umul;
                            cnt_d   = MulCntInit;
                            busy_d  = 1'b1;
                            state_d = StMul;
                        end
                        MD_DIV, MD_DIVU: begin
                            div_load = 1'b1;
                            opa_d    = bus.OpA;
                            qneg_d   = div_signed && (bus.OpA[31] ^ bus.OpB[31]);
                            rneg_d   = div_signed && bus.OpA[31];
                            div0_d   = (bus.OpB == 32'd0);
                            cnt_d    = DivCntInit;
                            busy_d   = 1'b1;
                            state_d  = StDiv;
                        end
                        MD_MTHI: hi_d = bus.OpA;
                        MD_MTLO: lo_d = bus.OpA;
                        default: ;
                    endcase
                end
            end
            StMul: begin
                if (bus.Abort) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else if (cnt_q == 5'd0) begin
                    {hi_d, lo_d} = prod_q;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            StDiv: begin
                if (bus.Abort) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    div_step = 1'b1;
                    if (cnt_q == 5'd0) begin
                        state_d = StFix;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
            end
            StFix: begin
                busy_d  = 1'b0;
                state_d = StIdle;
                if (!bus.Abort) begin
                    // Divide by zero bypasses sign fix: HI returns the raw dividend.
                    if (div0_q) begin
                        lo_d = 32'hFFFF_FFFF;
                        hi_d = opa_q;
                    end else begin
                        lo_d = qneg_q ? -div_quo : div_quo;
                        hi_d = rneg_q ? -div_rem : div_rem;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            prod_q  <= '0;
            opa_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            prod_q  <= prod_d;
            opa_q   <= opa_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            div0_q  <= div0_d;
        end
    end

    assign bus.Busy = busy_q;
    assign bus.Hi   = hi_q;
    assign bus.Lo   = lo_q;

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit with architectural HI/LO registers for the MIPS32 pipeline. Sits in EX, directly downstream of the register file: consumes the two register-file read operands (rs, rt) for MULT/MULTU/DIV/DIVU/MTHI/MTLO and supplies HI/LO to the MFHI/MFLO path. Multi-cycle operations raise `Busy`, which the hazard logic uses to stall the front of the pipeline.

## Interface
Parameters:
- `MUL_CYCLES`, default 4: cycles from accept to HI/LO commit for MULT/MULTU; legal range 1–8.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `Start`  input  1  request; sampled on an edge where `Busy`=0.
- `Op`  input  3  operation code, sampled with `Start`.
- `OpA`  input  32  rs operand (dividend / multiplicand / MTHI/MTLO source).
- `OpB`  input  32  rt operand (divisor / multiplier).
- `Abort`  input  1  exception flush; cancels an in-flight operation.
- `Busy`  output  1  operation in flight; new `Start` ignored while high.
- `Hi`  output  32  architectural HI register.
- `Lo`  output  32  architectural LO register.

## Operation
- Reset: `Hi`=0, `Lo`=0, `Busy`=0, state IDLE, iteration counter 0. Reset mid-operation discards it.
- States: IDLE, MUL, DIV, FIX.
  - IDLE + `Start` + MULT/MULTU → MUL. Operands latched; counter = `MUL_CYCLES`−1.
  - IDLE + `Start` + DIV/DIVU → DIV. Magnitudes latched; counter = 31.
  - IDLE + `Start` + MTHI/MTLO → write `OpA` to `Hi`/`Lo` at that edge; stay IDLE.
  - MUL: decrement each cycle; at counter 0, commit the 64-bit product {Hi,Lo} → IDLE.
  - DIV: one restoring quotient bit per cycle, MSB first; at counter 0 → FIX.
  - FIX: apply signs, commit `Lo`=quotient and `Hi`=remainder → IDLE.
- Unused `Op` codes with `Start`: no effect.
- `Start` while `Busy`=1: ignored. Control must hold the instruction stalled.
- Arithmetic:
  - MULT: signed 32×32→64.
  - MULTU: unsigned 32×32→64.
  - DIV: quotient sign = signA XOR signB; remainder sign = signA.
  - DIVU: unsigned.
- Boundaries:
  - Divide by zero, DIV or DIVU: `Lo`=32'hFFFFFFFF, `Hi`=`OpA` as given, no sign fix.
  - 0x80000000 / −1 (DIV): `Lo`=32'h80000000, `Hi`=0.
- `Abort`=1 in any non-IDLE state: next edge → IDLE, `Busy`=0, `Hi`/`Lo` unchanged.
- `Abort` in IDLE: suppresses a same-cycle `Start`, including MTHI/MTLO.
- No internal bypass. `Hi`/`Lo` change only on commit edges.

## Timing
- Accept edge is k. `Busy` rises after k.
- MULT/MULTU: commit at edge k+`MUL_CYCLES`; `Busy` falls at that same edge.
- DIV/DIVU: 32 iteration edges + 1 FIX edge. Commit at k+33; `Busy` high for 33 cycles.
- MTHI/MTLO: write at edge k; `Busy` stays 0. Back-to-back MT ops every cycle are legal.
- A new `Start` may be accepted on the edge after `Busy` falls.
- `Busy` is a registered output, glitch-free. It drops on the same edge as the commit, so MFHI/MFLO issued in the next cycle read the new values.

## Structure
- Shared package `md_pkg`: `Op` encodings MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5; state encoding; constant DIV_ITER=32.
- One natural sub-module: `md_divider`, the unsigned 32-bit restoring iteration datapath (remainder/quotient shift registers plus subtractor).
- Sign handling, multiply and FSM stay in `md_unit`.
- The multiply may be a single registered 64-bit product held until the counter expires.

## Test plan
- Reset then MULT OpA=−3 (32'hFFFFFFFD), OpB=7: `Busy` high 4 cycles; then Hi=32'hFFFFFFFF, Lo=32'hFFFFFFEB. MULTU with the same operands: Hi=32'h00000006, Lo=32'hFFFFFFEB.
- DIV −7 / 2: after 33 cycles Lo=32'hFFFFFFFD, Hi=32'hFFFFFFFF. DIVU 100/7: Lo=14, Hi=2.
- DIVU 5/0: Lo=32'hFFFFFFFF, Hi=5. DIV 32'h80000000 / 32'hFFFFFFFF: Lo=32'h80000000, Hi=0.
- MTHI 32'hDEADBEEF, then MTLO 32'h12345678 on consecutive cycles: `Busy` never rises; both visible one edge after each write.
- Start DIV, assert `Abort` at iteration 10: `Busy` falls next edge, Hi/Lo keep their prior values. `Start` pulsed while `Busy` is ignored. Async `rst` mid-MULT clears Hi/Lo/`Busy` immediately.
